// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// states, opcodes, ALU codes, mux selects and ALU-decode classes.
package mc_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALU_WB  = 4'd8,
      S_EXEC_U  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JAL     = 4'd11,
      S_JALR1   = 4'd12,
      S_JALR2   = 4'd13,
      S_ILLEGAL = 4'd14
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // ALU-decode classes: which rule picks ALUControl
   localparam logic [2:0] CLS_ADD = 3'd0;
   localparam logic [2:0] CLS_R   = 3'd1;
   localparam logic [2:0] CLS_I   = 3'd2;
   localparam logic [2:0] CLS_BR  = 3'd3;
   localparam logic [2:0] CLS_U   = 3'd4;

   // Immediate format depends only on the opcode
   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE:         imm_sel = IMM_S;
         OP_BR:            imm_sel = IMM_B;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         OP_JAL:           imm_sel = IMM_J;
         default:          imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation select for the multi-cycle controller.
// Maps decode class, funct3, funct7b5 and op[5] to ALUControl.
module mc_alu_decoder
   import mc_controller_pkg::*;
(
   input  logic [2:0] i_cls,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [3:0] o_alu_ctrl
);

   logic [3:0] w_arith;

   // Register/immediate arithmetic selected by funct3
   always_comb begin
      w_arith = ALU_ADD;
      case (i_funct3)
         3'b000: begin
            if (i_cls == CLS_R && i_funct7b5)
               w_arith = ALU_SUB;
            else
               w_arith = ALU_ADD;
         end
         3'b001: w_arith = ALU_SLL;
         3'b010: w_arith = ALU_SLT;
         3'b011: w_arith = ALU_SLTU;
         3'b100: w_arith = ALU_XOR;
         3'b101: w_arith = i_funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110: w_arith = ALU_OR;
         3'b111: w_arith = ALU_AND;
         default: w_arith = ALU_ADD;
      endcase
   end

   // Final selection by decode class
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_cls)
         CLS_R, CLS_I: o_alu_ctrl = w_arith;
         CLS_BR: begin
            case (i_funct3[2:1])
               2'b00:   o_alu_ctrl = ALU_SUB;
               2'b10:   o_alu_ctrl = ALU_SLT;
               2'b11:   o_alu_ctrl = ALU_SLTU;
               default: o_alu_ctrl = ALU_SUB;
            endcase
         end
         CLS_U:   o_alu_ctrl = i_op5 ? ALU_PASSB : ALU_ADD;
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM with memory wait handshake
// and a sticky illegal-opcode halt state.
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       retire,
   output logic       illegal_op
);

   state_e     r_state;
   state_e     w_dec_next;
   logic       w_rdy;
   logic       w_taken;
   logic [2:0] w_cls;

   assign w_rdy  = (MEM_HANDSHAKE == 0) || mem_ready;
   assign ImmSrc = imm_sel(op);

   // Dispatch target chosen in DECODE
   always_comb begin
      w_dec_next = S_ILLEGAL;
      case (op)
         OP_LOAD, OP_STORE: w_dec_next = S_MEM_ADR;
         OP_R:              w_dec_next = S_EXEC_R;
         OP_I:              w_dec_next = S_EXEC_I;
         OP_BR: begin
            if (funct3[2:1] == 2'b01)
               w_dec_next = S_ILLEGAL;
            else
               w_dec_next = S_BRANCH;
         end
         OP_JAL:            w_dec_next = S_JAL;
         OP_JALR:           w_dec_next = S_JALR1;
         OP_LUI, OP_AUIPC:  w_dec_next = S_EXEC_U;
         default:           w_dec_next = S_ILLEGAL;
      endcase
   end

   // Branch outcome from the compare result in Zero
   always_comb begin
      w_taken = 1'b0;
      case (funct3)
         3'b000:          w_taken = Zero;
         3'b001:          w_taken = ~Zero;
         3'b100, 3'b110:  w_taken = ~Zero;
         3'b101, 3'b111:  w_taken = Zero;
         default:         w_taken = 1'b0;
      endcase
   end

   // State register and next-state sequencing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:   if (w_rdy) r_state <= S_DECODE;
            S_DECODE:  r_state <= w_dec_next;
            S_MEM_ADR: r_state <= op[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (w_rdy) r_state <= S_MEM_WB;
            S_MEM_WB:  r_state <= S_FETCH;
            S_MEM_WR:  if (w_rdy) r_state <= S_FETCH;
            S_EXEC_R:  r_state <= S_ALU_WB;
            S_EXEC_I:  r_state <= S_ALU_WB;
            S_ALU_WB:  r_state <= S_FETCH;
            S_EXEC_U:  r_state <= S_ALU_WB;
            S_BRANCH:  r_state <= S_FETCH;
            S_JAL:     r_state <= S_ALU_WB;
            S_JALR1:   r_state <= S_JALR2;
            S_JALR2:   r_state <= S_ALU_WB;
            S_ILLEGAL: r_state <= S_ILLEGAL;
            default:   r_state <= S_ILLEGAL;
         endcase
      end
   end

   // Per-state control decode; reset forces strobes low
   always_comb begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      retire     = 1'b0;
      illegal_op = 1'b0;
      w_cls      = CLS_ADD;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            IRWrite   = w_rdy;
            PCWrite   = w_rdy;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_ADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEM_WB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEM_WR: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            retire   = w_rdy;
         end
         S_EXEC_R: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            w_cls   = CLS_R;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            w_cls   = CLS_I;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_EXEC_U: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            w_cls   = CLS_U;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            w_cls   = CLS_BR;
            PCWrite = w_taken;
            retire  = 1'b1;
         end
         S_JAL, S_JALR2: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         S_JALR1: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_ILLEGAL: illegal_op = 1'b1;
         default:   illegal_op = 1'b1;
      endcase
      if (reset) begin
         mem_req    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         retire     = 1'b0;
         illegal_op = 1'b0;
      end
   end

   mc_alu_decoder u_alu_dec (
      .i_cls      (w_cls),
      .i_funct3   (funct3),
      .i_funct7b5 (funct7b5),
      .i_op5      (op[5]),
      .o_alu_ctrl (ALUControl)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios
// plus randomized instructions against a latency/strobe model.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite;
   logic       RegWrite, retire, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;

   int checks = 0;
   int failures = 0;

   logic       t_req[64], t_mw[64], t_adr[64], t_irw[64];
   logic       t_pcw[64], t_rw[64], t_ret[64], t_ill[64];
   logic [1:0] t_rs[64], t_sa[64];
   logic [2:0] t_imm[64];
   logic [3:0] t_alu[64];

   always #5 clk = ~clk;

   mc_controller #(.MEM_HANDSHAKE(1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .retire(retire),
      .illegal_op(illegal_op)
   );

   // Instruction kinds used by the model
   localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3;
   localparam int K_LD = 4, K_ST = 5, K_BR = 6, K_JAL = 7;
   localparam int K_JALR = 8;

   function automatic logic [6:0] kind_op(input int k);
      case (k)
         K_R:     return 7'h33;
         K_I:     return 7'h13;
         K_LUI:   return 7'h37;
         K_AUIPC: return 7'h17;
         K_LD:    return 7'h03;
         K_ST:    return 7'h23;
         K_BR:    return 7'h63;
         K_JAL:   return 7'h6F;
         default: return 7'h67;
      endcase
   endfunction

   function automatic int kind_lat(input int k);
      case (k)
         K_LD, K_JALR: return 5;
         K_BR:         return 3;
         default:      return 4;
      endcase
   endfunction

   function automatic logic [2:0] kind_imm(input int k);
      case (k)
         K_ST:            return 3'b001;
         K_BR:            return 3'b010;
         K_LUI, K_AUIPC:  return 3'b011;
         K_JAL:           return 3'b100;
         default:         return 3'b000;
      endcase
   endfunction

   // Operation the ALU must perform in the first post-decode cycle
   function automatic logic [3:0] kind_alu(input int k,
      input logic [2:0] f3, input logic f7);
      string m;
      m = "add";
      if (k == K_R || k == K_I) begin
         case (f3)
            3'd0: m = (k == K_R && f7) ? "sub" : "add";
            3'd1: m = "sll";
            3'd2: m = "slt";
            3'd3: m = "sltu";
            3'd4: m = "xor";
            3'd5: m = f7 ? "sra" : "srl";
            3'd6: m = "or";
            default: m = "and";
         endcase
      end else if (k == K_BR) begin
         if (f3 <= 3'd1) m = "sub";
         else if (f3 <= 3'd5) m = "slt";
         else m = "sltu";
      end else if (k == K_LUI) begin
         m = "passb";
      end
      case (m)
         "sub":   return 4'b0001;
         "and":   return 4'b0010;
         "or":    return 4'b0011;
         "xor":   return 4'b0100;
         "slt":   return 4'b0101;
         "sltu":  return 4'b0110;
         "sll":   return 4'b0111;
         "srl":   return 4'b1000;
         "sra":   return 4'b1001;
         "passb": return 4'b1010;
         default: return 4'b0000;
      endcase
   endfunction

   // beq/bge family taken on equal-or-false-compare, others on nonzero
   function automatic logic br_taken(input logic [2:0] f3,
      input logic z);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return !z;
         3'd5:    return z;
         3'd6:    return !z;
         default: return z;
      endcase
   endfunction

   // Runs one instruction; wf fetch waits, wm data waits
   task automatic run_instr(input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic z,
      input int wf, input int wm, input int limit,
      output int cyc);
      for (int i = 0; i < 64; i++) begin
         t_req[i] = 0; t_mw[i] = 0; t_adr[i] = 0; t_irw[i] = 0;
         t_pcw[i] = 0; t_rw[i] = 0; t_ret[i] = 0; t_ill[i] = 0;
         t_rs[i] = 0; t_sa[i] = 0; t_imm[i] = 0; t_alu[i] = 0;
      end
      cyc = limit;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (k == 1) begin
            op = o; funct3 = f3; funct7b5 = f7; Zero = z;
         end
         mem_ready = !(k <= wf || (k >= wf + 4 && k < wf + 4 + wm));
         #4;
         t_req[k] = mem_req;  t_mw[k] = MemWrite;
         t_adr[k] = AdrSrc;   t_irw[k] = IRWrite;
         t_pcw[k] = PCWrite;  t_rw[k] = RegWrite;
         t_ret[k] = retire;   t_ill[k] = illegal_op;
         t_rs[k] = ResultSrc; t_sa[k] = ALUSrcA;
         t_imm[k] = ImmSrc;   t_alu[k] = ALUControl;
         if (retire === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      mem_ready = 0;
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; mem_ready = 0; op = 7'h33; funct3 = 0;
      funct7b5 = 0; Zero = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite,
           retire, illegal_op} !== 7'b0) begin
         failures++;
         $display("FAIL reset_strobes got=%b want=0000000",
            {mem_req, MemWrite, IRWrite, PCWrite, RegWrite,
             retire, illegal_op});
      end
      checks++;
      if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
          !== {1'b0, 2'b10, 2'b00, 2'b10, 4'b0000}) begin
         failures++;
         $display("FAIL reset_fetch_sel got=%b want=0100010 0000",
            {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl});
      end
      reset = 0;
   endtask

   task automatic test_add();
      int c;
      run_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 12, c);
      checks++;
      if (c !== 4) begin
         failures++;
         $display("FAIL add_cycles got=%0d want=4", c);
      end
      checks++;
      if ({t_rw[1], t_rw[2], t_rw[3], t_rw[4]} !== 4'b0001 ||
          {t_ret[1], t_ret[2], t_ret[3]} !== 3'b000) begin
         failures++;
         $display("FAIL add_regwrite got=%b%b%b%b want=0001",
            t_rw[1], t_rw[2], t_rw[3], t_rw[4]);
      end
      checks++;
      if (t_sa[3] !== 2'b10 || t_alu[3] !== 4'b0000) begin
         failures++;
         $display("FAIL add_exec got=%b/%b want=10/0000",
            t_sa[3], t_alu[3]);
      end
   endtask

   task automatic test_lw_wait();
      int c;
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 2, 12, c);
      checks++;
      if (c !== 7) begin
         failures++;
         $display("FAIL lw_wait_cycles got=%0d want=7", c);
      end
      checks++;
      if ({t_req[4], t_req[5], t_req[6], t_adr[4], t_adr[5],
           t_adr[6]} !== 6'b111111 || t_rw[7] !== 1'b1 ||
          t_rs[7] !== 2'b01) begin
         failures++;
         $display("FAIL lw_wait_mem got=%b%b%b %b%b%b want=111 111",
            t_req[4], t_req[5], t_req[6], t_adr[4], t_adr[5], t_adr[6]);
      end
   endtask

   task automatic test_branch();
      int c;
      run_instr(7'h63, 3'd1, 1'b0, 1'b1, 0, 0, 12, c);
      checks++;
      if (c !== 3 || t_pcw[3] !== 1'b0) begin
         failures++;
         $display("FAIL bne_z1 got=%0d/%b want=3/0", c, t_pcw[3]);
      end
      run_instr(7'h63, 3'd1, 1'b0, 1'b0, 0, 0, 12, c);
      checks++;
      if (c !== 3 || t_pcw[3] !== 1'b1) begin
         failures++;
         $display("FAIL bne_z0 got=%0d/%b want=3/1", c, t_pcw[3]);
      end
      run_instr(7'h63, 3'd6, 1'b0, 1'b0, 0, 0, 12, c);
      checks++;
      if (t_alu[3] !== 4'b0110) begin
         failures++;
         $display("FAIL bltu_alu got=%b want=0110", t_alu[3]);
      end
   endtask

   task automatic test_jalr();
      int c;
      run_instr(7'h67, 3'd0, 1'b0, 1'b0, 0, 0, 12, c);
      checks++;
      if (c !== 5) begin
         failures++;
         $display("FAIL jalr_cycles got=%0d want=5", c);
      end
      checks++;
      if (t_pcw[3] !== 1'b0 || t_pcw[4] !== 1'b1 ||
          t_rs[4] !== 2'b00 || t_rw[5] !== 1'b1) begin
         failures++;
         $display("FAIL jalr_seq got=%b%b/%b/%b want=01/00/1",
            t_pcw[3], t_pcw[4], t_rs[4], t_rw[5]);
      end
   endtask

   task automatic test_illegal();
      int c;
      int bad;
      int ill;
      run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 10, c);
      bad = 0;
      ill = 0;
      for (int k = 2; k <= 10; k++) begin
         bad += int'(t_rw[k]) + int'(t_pcw[k]) + int'(t_mw[k])
              + int'(t_irw[k]) + int'(t_ret[k]);
         if (k >= 3) ill += int'(t_ill[k]);
      end
      checks++;
      if (c !== 10 || bad !== 0) begin
         failures++;
         $display("FAIL illegal_nowrite got=%0d/%0d want=10/0", c, bad);
      end
      checks++;
      if (ill !== 8 || t_ill[2] !== 1'b0) begin
         failures++;
         $display("FAIL illegal_flag got=%0d want=8", ill);
      end
      @(negedge clk);
      reset = 1;
      #1;
      checks++;
      if (illegal_op !== 1'b0) begin
         failures++;
         $display("FAIL illegal_reset got=%b want=0", illegal_op);
      end
      mem_ready = 0;
      @(negedge clk);
      reset = 0;
      run_instr(7'h63, 3'd2, 1'b0, 1'b0, 0, 0, 4, c);
      checks++;
      if (t_ill[3] !== 1'b1 || c !== 4) begin
         failures++;
         $display("FAIL br_f3_illegal got=%b want=1", t_ill[3]);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_store();
      int c;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            op = 7'h23; funct3 = 3'd2; funct7b5 = 0;
         end
         mem_ready = (k <= 3);
      end
      #2;
      checks++;
      if (MemWrite !== 1'b1 || mem_req !== 1'b1) begin
         failures++;
         $display("FAIL st_before_rst got=%b%b want=11",
            MemWrite, mem_req);
      end
      reset = 1;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || mem_req !== 1'b0 || retire !== 1'b0) begin
         failures++;
         $display("FAIL st_abort got=%b%b%b want=000",
            MemWrite, mem_req, retire);
      end
      @(negedge clk);
      reset = 0;
      run_instr(7'h33, 3'd7, 1'b0, 1'b0, 0, 0, 12, c);
      checks++;
      if (c !== 4 || t_irw[1] !== 1'b1) begin
         failures++;
         $display("FAIL st_refetch got=%0d want=4", c);
      end
   endtask

   task automatic test_random();
      int c, k, wf, wm, cr, cp, cm, ci;
      int er, ep, em;
      logic [2:0] f3;
      logic f7, z;
      logic [2:0] brf[6];
      brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      for (int n = 0; n < 200; n++) begin
         k  = $urandom_range(8);
         f3 = 3'($urandom_range(7));
         if (k == K_BR) f3 = brf[$urandom_range(5)];
         f7 = 1'($urandom_range(1));
         z  = 1'($urandom_range(1));
         wf = $urandom_range(2);
         wm = $urandom_range(3);
         run_instr(kind_op(k), f3, f7, z, wf, wm, 20, c);
         cr = 0; cp = 0; cm = 0; ci = 0;
         for (int j = 1; j <= c; j++) begin
            cr += int'(t_rw[j]);
            cp += int'(t_pcw[j]);
            cm += int'(t_mw[j]);
            ci += int'(t_irw[j]);
         end
         er = (k == K_ST || k == K_BR) ? 0 : 1;
         ep = 1 + ((k == K_JAL || k == K_JALR) ? 1 : 0)
                + ((k == K_BR && br_taken(f3, z)) ? 1 : 0);
         em = (k == K_ST) ? 1 + wm : 0;
         checks++;
         if (c !== kind_lat(k) + wf +
             ((k == K_LD || k == K_ST) ? wm : 0)) begin
            failures++;
            $display("FAIL rnd_cycles n=%0d k=%0d got=%0d wf=%0d wm=%0d",
               n, k, c, wf, wm);
         end
         checks++;
         if (cr !== er || cp !== ep || cm !== em) begin
            failures++;
            $display("FAIL rnd_strobes n=%0d k=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
               n, k, cr, cp, cm, er, ep, em);
         end
         checks++;
         if (ci !== 1 || t_irw[wf + 1] !== 1'b1) begin
            failures++;
            $display("FAIL rnd_irwrite n=%0d got=%0d want=1", n, ci);
         end
         checks++;
         if (t_alu[wf + 3] !== kind_alu(k, f3, f7)) begin
            failures++;
            $display("FAIL rnd_alu n=%0d k=%0d f3=%0d got=%b want=%b",
               n, k, f3, t_alu[wf + 3], kind_alu(k, f3, f7));
         end
         checks++;
         if (t_imm[1] !== kind_imm(k)) begin
            failures++;
            $display("FAIL rnd_imm n=%0d k=%0d got=%b want=%b",
               n, k, t_imm[1], kind_imm(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jalr();
      test_illegal();
      test_reset_mid_store();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
